rasterizer_fb: RTL and testbench

Pixel-write rasterizer back end with an integrated 320x240, 8-bit frame buffer. Accepts single-pixel write requests (x, y, color), converts coordinates to a linear address, and writes the frame buffer one cycle later. Also provides a hardware clear sequencer and an independent synchronous read port for scan-out or debug. Sits between the pixel-generation pipeline and the display controller.

---
 rtl/raster_pkg.sv | 16 +
 rtl/frame_buffer.sv | 38 +++
 rtl/rasterizer_fb.sv | 125 ++++++++++++
 tb/tb_rasterizer_fb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared constants and types for the rasterizer back end and its frame buffer.
package raster_pkg;

  localparam int H_RES    = 320;
  localparam int V_RES    = 240;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 17;
  localparam int COLOR_W  = 8;

  // Write-side sequencer: normal pixel writes, or a full-screen fill.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

endpackage : raster_pkg

// File: rtl/frame_buffer.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old data.
module frame_buffer #(
  parameter int DEPTH  = 76800,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; the top level only ever presents in-range addresses here.
  // NOTE: the array has no reset branch -- clearing a RAM on reset would turn it into flops; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Registered read port; addresses past the end of the screen read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (32'(rd_addr) < DEPTH) begin
      data_out <= mem[rd_addr];
    end else begin
      data_out <= '0;
    end
  end

endmodule : frame_buffer

// File: rtl/rasterizer_fb.sv
// Pixel-write rasterizer back end: converts (x, y) to a linear address, drops
// off-screen pixels, registers the write, and can fill the whole screen with a
// single colour. Owns the frame buffer and exposes an independent read port.
module rasterizer_fb #(
  parameter int H_RES   = raster_pkg::H_RES,
  parameter int V_RES   = raster_pkg::V_RES,
  parameter int COLOR_W = raster_pkg::COLOR_W,
  parameter int ADDR_W  = raster_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8:0]         pixel_x,
  input  logic [8:0]         pixel_y,
  input  logic [COLOR_W-1:0] pixel_color,
  input  logic               pixel_valid,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               busy,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COLOR_W-1:0] rd_data
);

  import raster_pkg::*;

  localparam int                DEPTH     = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;

  logic               fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0] fb_data_q, fb_data_d;

  logic [ADDR_W-1:0]  pix_addr;
  logic               pix_in_range;

  // Row-major linear address and on-screen test for the incoming pixel.
  always_comb begin
    pix_addr     = ADDR_W'(ADDR_W'(pixel_y) * ADDR_W'(H_RES) + ADDR_W'(pixel_x));
    pix_in_range = (32'(pixel_x) < H_RES) && (32'(pixel_y) < V_RES);
  end

  // Next-state logic: pixel writes in IDLE, one fill write per cycle in CLEAR.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable unassigned (no latch).
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;

    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          // Clear has priority; a coincident pixel request is dropped.
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          clr_color_d = clear_color;
        end else if (pixel_valid && pix_in_range) begin
          fb_we_d   = 1'b1;
          fb_addr_d = pix_addr;
          fb_data_d = pixel_color;
        end
      end

      CLEAR: begin
        // Pixel requests and further clear_start pulses are ignored here.
        fb_we_d   = 1'b1;
        fb_addr_d = clr_cnt_q;
        fb_data_d = clr_color_q;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and write-stage registers; reset cancels any write in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
    end
  end

  // Busy for exactly the cycles the sequencer spends filling the screen.
  always_comb begin
    busy = (state_q == CLEAR);
  end

  frame_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (COLOR_W)
  ) u_frame_buffer (
    .clk      (clk),
    .reset    (reset),
    .we       (fb_we_q),
    .wr_addr  (fb_addr_q),
    .data_in  (fb_data_q),
    .rd_addr  (rd_addr),
    .data_out (rd_data)
  );

endmodule : rasterizer_fb

// File: tb/tb_rasterizer_fb.sv
// Self-checking bench for rasterizer_fb: a directed vector table, hand-written
// corner sequences (held valid, read-first, full clear, reset mid-clear) and a
// randomized phase checked against a simple array model of the screen.
module tb_rasterizer_fb;

  localparam int H     = 320;
  localparam int V     = 240;
  localparam int DEPTH = H * V;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  pixel_x, pixel_y;
  logic [7:0]  pixel_color;
  logic        pixel_valid;
  logic        clear_start;
  logic [7:0]  clear_color;
  logic        busy;
  logic [16:0] rd_addr;
  logic [7:0]  rd_data;

  always #5 clk = ~clk;

  rasterizer_fb #(
    .H_RES   (H),
    .V_RES   (V),
    .COLOR_W (8),
    .ADDR_W  (17)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color),
    .pixel_valid (pixel_valid),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .busy        (busy),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          is_wr;
    int          x;
    int          y;
    logic [7:0]  color;
    int          addr;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  // Screen model used by the randomized phase.
  logic [7:0] model [DEPTH];
  int         recent[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int x, input int y, input logic [7:0] c);
    pixel_x     = 9'(x);
    pixel_y     = 9'(y);
    pixel_color = c;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    tick();
  endtask

  task automatic read_chk(input string name, input int a, input logic [7:0] exp);
    rd_addr = 17'(a);
    tick();
    check(name, 32'(rd_data), 32'(exp));
  endtask

  function automatic vec_t wr(input int x, input int y, input logic [7:0] c);
    vec_t v;
    v.is_wr = 1'b1; v.x = x; v.y = y; v.color = c; v.addr = 0; v.exp = 8'h00;
    return v;
  endfunction

  function automatic vec_t rd(input int a, input logic [7:0] e);
    vec_t v;
    v.is_wr = 1'b0; v.x = 0; v.y = 0; v.color = 8'h00; v.addr = a; v.exp = e;
    return v;
  endfunction

  initial begin
    int         cnt;
    bit         pend;
    int         pend_a;
    logic [7:0] pend_c;
    logic [7:0] exp_rd;
    int         ra;

    // ---------------- reset ----------------
    reset       = 1'b1;
    pixel_x     = '0;
    pixel_y     = '0;
    pixel_color = '0;
    pixel_valid = 1'b0;
    clear_start = 1'b0;
    clear_color = '0;
    rd_addr     = '0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    tick();

    // ---------------- directed table ----------------
    vecs.push_back(wr(0, 0, 8'hFF));
    vecs.push_back(wr(1, 1, 8'hAA));
    vecs.push_back(wr(319, 239, 8'h55));
    vecs.push_back(wr(0, 1, 8'h66));
    vecs.push_back(wr(191, 1, 8'h67));
    vecs.push_back(wr(160, 2, 8'h42));
    vecs.push_back(rd(0, 8'hFF));
    vecs.push_back(rd(321, 8'hAA));
    vecs.push_back(rd(76799, 8'h55));
    vecs.push_back(rd(800, 8'h42));
    // Off-screen writes: x aliases would land on 320 / 511 if not dropped.
    vecs.push_back(wr(320, 0, 8'h11));
    vecs.push_back(wr(511, 0, 8'h12));
    vecs.push_back(wr(0, 240, 8'h22));
    vecs.push_back(wr(300, 250, 8'h33));
    vecs.push_back(rd(0, 8'hFF));
    vecs.push_back(rd(76799, 8'h55));
    vecs.push_back(rd(320, 8'h66));
    vecs.push_back(rd(511, 8'h67));
    vecs.push_back(rd(76800, 8'h00));
    vecs.push_back(rd(131071, 8'h00));

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) write_px(vecs[i].x, vecs[i].y, vecs[i].color);
      else read_chk($sformatf("table_rd[%0d]", i), vecs[i].addr, vecs[i].exp);
    end

    // ---------------- held pixel_valid for 4 cycles ----------------
    for (int i = 0; i < 4; i++) begin
      pixel_x     = 9'(10 + i);
      pixel_y     = 9'd2;
      pixel_color = 8'(i + 1);
      pixel_valid = 1'b1;
      tick();
    end
    pixel_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) read_chk("held_valid", 2 * H + 10 + i, 8'(i + 1));

    // ---------------- read-first on a same-edge collision ----------------
    pixel_x     = 9'd160;
    pixel_y     = 9'd2;
    pixel_color = 8'h99;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    rd_addr     = 17'd800;
    tick();
    check("read_first_old", 32'(rd_data), 32'h42);
    tick();
    check("read_first_new", 32'(rd_data), 32'h99);

    // ---------------- full clear ----------------
    check("busy_before_clear", 32'(busy), 32'd0);
    clear_color = 8'h3C;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    clear_color = 8'h00;
    cnt = 0;
    while (busy === 1'b1 && cnt < 80000) begin
      cnt++;
      // A second clear request and a pixel write, both of which must be ignored.
      clear_start = (cnt == 40000);
      pixel_x     = 9'd5;
      pixel_y     = 9'd5;
      pixel_color = 8'h77;
      pixel_valid = (cnt == 50000);
      tick();
    end
    clear_start = 1'b0;
    pixel_valid = 1'b0;
    check("busy_cycles", 32'(cnt), 32'd76800);
    tick();
    read_chk("clear_addr0", 0, 8'h3C);
    read_chk("clear_addr321", 321, 8'h3C);
    read_chk("clear_addr76799", 76799, 8'h3C);
    read_chk("clear_drop_1605", 5 * H + 5, 8'h3C);

    // ---------------- randomized traffic vs model ----------------
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h3C;
    pend = 1'b0;
    pend_a = 0;
    pend_c = 8'h00;
    for (int i = 0; i < 600; i++) begin
      pixel_valid = ($urandom_range(0, 3) != 0);
      pixel_x     = 9'($urandom_range(0, 339));
      pixel_y     = 9'($urandom_range(0, 249));
      pixel_color = 8'($urandom);
      if (recent.size() > 0 && $urandom_range(0, 1) == 1)
        ra = recent[$urandom_range(0, recent.size() - 1)];
      else if ($urandom_range(0, 7) == 0)
        ra = int'($urandom_range(DEPTH, 131071));
      else
        ra = int'($urandom_range(0, DEPTH - 1));
      rd_addr = 17'(ra);
      exp_rd  = (ra < DEPTH) ? model[ra] : 8'h00;
      tick();
      // The write requested last cycle lands at this edge, after the read.
      if (pend) model[pend_a] = pend_c;
      pend   = pixel_valid && (int'(pixel_x) < H) && (int'(pixel_y) < V);
      pend_a = int'(pixel_y) * H + int'(pixel_x);
      pend_c = pixel_color;
      if (pend) begin
        recent.push_back(pend_a);
        if (recent.size() > 16) void'(recent.pop_front());
      end
      check("rand_rd", 32'(rd_data), 32'(exp_rd));
    end
    pixel_valid = 1'b0;
    tick();
    if (pend) model[pend_a] = pend_c;

    // ---------------- reset in the middle of a clear ----------------
    clear_color = 8'hA5;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (1000) tick();
    check("busy_mid_clear", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("reset_mid_busy", 32'(busy), 32'd0);
    check("reset_mid_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    tick();
    check("after_reset_busy", 32'(busy), 32'd0);
    read_chk("partial_clear_lo", 10, 8'hA5);
    read_chk("partial_clear_hi", 50000, model[50000]);
    write_px(7, 7, 8'h5A);
    read_chk("post_reset_write", 7 * H + 7, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rasterizer_fb
